// File: rtl/feeder_pkg.sv
// Shared definitions for the serial word feeder.
//   DEFAULT_WIDTH / DEFAULT_LEN_W / DEFAULT_CNT_W : default parameter values
//   state_t : feeder FSM encoding (IDLE=0, SHIFT=1)
//   eff_len : maps a requested length onto the range 1..width
package feeder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_LEN_W = 5;
    localparam int unsigned DEFAULT_CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // A length of 0 or anything above the word width means "send the full word".
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        if (len == 0 || len > width) begin
            return width;
        end
        return len;
    endfunction

endpackage

// File: rtl/feeder_hold_buf.sv
// One-entry holding buffer for a word and its effective length.
//   clk, rst          : clock, async active-high reset
//   wr, wr_data/len   : write strobe and payload
//   rd                : read strobe (entry moves to the shifter)
//   data, len, full   : stored entry and its occupancy flag
//   ready             : buffer can take a word (combinational)
module feeder_hold_buf
    import feeder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [LEN_W-1:0] wr_len,
    input  logic             rd,
    output logic [WIDTH-1:0] data,
    output logic [LEN_W-1:0] len,
    output logic             full,
    output logic             ready
);

    // A write on the same edge as a read refills the entry, so it wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            len  <= LEN_W'(WIDTH);
            full <= 1'b0;
        end else begin
            if (rd) begin
                full <= 1'b0;
            end
            if (wr) begin
                data <= wr_data;
                len  <= wr_len;
                full <= 1'b1;
            end
        end
    end

    assign ready = !full;

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder, LSB first, with a one-entry skid buffer.
//   clk, rst               : clock, async active-high reset
//   in_valid/in_ready      : upstream handshake
//   in_data, in_len        : word and bit count (0 or >WIDTH means WIDTH)
//   ser_en                 : downstream advance strobe
//   ser_bit, ser_valid     : serial output
//   frame_start, frame_end : first / last bit of a word is presented
//   words_sent             : count of fully consumed words (wraps)
module serial_word_feeder
    import feeder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned LEN_W = DEFAULT_LEN_W,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [LEN_W-1:0] in_len,
    input  logic             ser_en,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic [CNT_W-1:0] words_sent
);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   sh;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len_q;

    logic [WIDTH-1:0]   hold_data;
    logic [LEN_W-1:0]   hold_len;
    logic               hold_full;

    logic [LEN_W-1:0]   in_len_eff;
    logic               accept;
    logic               adv;
    logic               last;
    logic               load_slot;
    logic               load_hold;
    logic               load_bypass;
    logic               load;
    logic               hold_wr;
    logic [WIDTH-1:0]   load_data;
    logic [LEN_W-1:0]   load_len;

    assign in_len_eff = LEN_W'(eff_len(32'(in_len), WIDTH));

    // Handshake and load decisions.
    assign accept      = in_valid && in_ready;
    assign adv         = ser_valid && ser_en;
    assign last        = (cnt == LEN_W'(len_q - LEN_W'(1)));
    assign load_slot   = (state == IDLE) || (adv && last);
    assign load_hold   = load_slot && hold_full;
    assign load_bypass = load_slot && !hold_full && accept;
    assign load        = load_hold || load_bypass;
    assign hold_wr     = accept && !load_slot;
    assign load_data   = hold_full ? hold_data : in_data;
    assign load_len    = hold_full ? hold_len  : in_len_eff;

    feeder_hold_buf #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .wr      (hold_wr),
        .wr_data (in_data),
        .wr_len  (in_len_eff),
        .rd      (load_hold),
        .data    (hold_data),
        .len     (hold_len),
        .full    (hold_full),
        .ready   (in_ready)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: every load slot either reloads or drains to IDLE.
    always_comb begin
        state_next = state;
        if (load_slot) begin
            state_next = load ? SHIFT : IDLE;
        end
    end

    // Output decode.
    always_comb begin
        ser_valid   = (state == SHIFT);
        ser_bit     = sh[0];
        frame_start = ser_valid && (cnt == '0);
        frame_end   = ser_valid && last;
    end

    // Shifter, bit counter and length register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh    <= '0;
            cnt   <= '0;
            len_q <= LEN_W'(WIDTH);
        end else if (load) begin
            sh    <= load_data;
            cnt   <= '0;
            len_q <= load_len;
        end else if (adv && !last) begin
            sh    <= {1'b0, sh[WIDTH-1:1]};
            cnt   <= cnt + LEN_W'(1);
        end
    end

    // Completed-word counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_sent <= '0;
        end else if (adv && last) begin
            words_sent <= words_sent + CNT_W'(1);
        end
    end

endmodule
